// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

    localparam int ENTRY_PC_W    = 32;
    localparam int ENTRY_INSTR_W = 32;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [ENTRY_INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;
    localparam int unsigned              PC_STEP   = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular prefetch buffer of fetch entries; flush has priority over push/pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential PC generation, credit-limited issue, prefetch queue.
// Optional macro IFETCH_PERF_EN adds the perf_stall_cycles decode-stall counter.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_p1;
    logic              vld_p1;
    logic              squash_p1;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Outstanding request counts against queue space so a push never meets a full queue.
    assign credit_used = {1'b0, count} + (CNT_W+1)'(vld_p1);
    assign issue       = rst && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign push       = vld_p1 && !squash_p1 && !redirect_valid;
    assign push_entry = '{pc: ENTRY_PC_W'(pc_p1), instr: ENTRY_INSTR_W'(imem_rdata)};

    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? DATA_W'(head.instr) : DATA_W'(INSTR_NOP);
    assign out_pc    = out_valid ? ADDR_W'(head.pc) : '0;

    // Stage p0 -> p1: request issued, response expected next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            vld_p1    <= 1'b0;
            squash_p1 <= 1'b0;
        end else begin
            vld_p1    <= issue;
            squash_p1 <= redirect_valid;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= fetch_pc;
        end
    end

    // Stage p1 -> queue: response captured with its PC.
    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

`ifdef IFETCH_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
        end else if (out_valid && !out_ready) begin
            perf_stall_cycles <= sat_inc32(perf_stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: expected outputs queued by stimulus, popped by a monitor.
module tb_ifetch_prefetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic        w_ready;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf;
    logic [31:0] w_perf;
`endif

    int          checks = 0;
    int          errors = 0;
    int          acc    = 0;
    int          tgt    = 0;
    int          nreq;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    ifetch_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
`ifdef IFETCH_PERF_EN
        ,
        .perf_stall_cycles (perf)
`endif
    );

    ifetch_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (w_redirect),
        .redirect_pc    (w_redirect_pc),
        .out_valid      (w_out_valid),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .out_ready      (w_ready)
`ifdef IFETCH_PERF_EN
        ,
        .perf_stall_cycles (w_perf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: returns the requested address xor a tag, one cycle later.
    always @(posedge clk) begin
        imem_rdata <= imem_addr ^ 32'hDEAD_0000;
        w_rdata    <= w_addr ^ 32'hDEAD_0000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int expect_iters);
        int iters = 0;
        while (acc < tgt && iters < 60) begin
            tick();
            iters++;
            out_ready = (acc < tgt);
        end
        out_ready = 1'b0;
        check("drain_done", 32'(acc), 32'(tgt));
        if (expect_iters >= 0) begin
            check("drain_cycles", 32'(iters), 32'(expect_iters));
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            acc++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got pc %h, expected no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, e ^ 32'hDEAD_0000);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_redirect     = 1'b0;
        w_redirect_pc  = '0;
        w_ready        = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_req",    32'(imem_req),  32'd0);
        check("rst_addr",   imem_addr,      32'h0);
        check("rst_vld",    32'(out_valid), 32'd0);
        check("rst_instr",  out_instr,      32'h0);
        check("rst_pc",     out_pc,         32'h0);
        check("rst_w_addr", w_addr,         32'hFFFF_FFF8);
`ifdef IFETCH_PERF_EN
        check("rst_perf",   perf,           32'h0);
`endif
        tick();
        tick();

        // Streaming from reset with decode always ready.
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        tgt = acc + 10;
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("a_req0",   32'(imem_req), 32'd1);
        check("a_addr0",  imem_addr,     32'h0);
        check("a_w_addr0", w_addr,       32'hFFFF_FFF8);
        tick();
        out_ready = (acc < tgt);
        #1;
        check("a_addr1",  imem_addr,      32'h4);
        check("a_vld1",   32'(out_valid), 32'd0);
        check("a_w_addr1", w_addr,        32'hFFFF_FFFC);
        tick();
        out_ready = (acc < tgt);
        #1;
        check("a_vld2",   32'(out_valid), 32'd1);
        check("a_pc2",    out_pc,         32'h0);
        check("a_addr2",  imem_addr,      32'h8);
        check("a_w_addr2", w_addr,        32'h0);
        drain(10);

        // Asynchronous reset mid-stream.
        #1;
        check("ar_pre_vld", 32'(out_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("ar_req",    32'(imem_req),  32'd0);
        check("ar_addr",   imem_addr,      32'h0);
        check("ar_vld",    32'(out_valid), 32'd0);
        check("ar_pc",     out_pc,         32'h0);
        check("ar_instr",  out_instr,      32'h0);
        check("ar_w_addr", w_addr,         32'hFFFF_FFF8);

        // Decode stall from the start: queue fills, fetch stops, then resumes after a pop.
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        nreq = int'(imem_req);
        repeat (9) begin
            tick();
            nreq += int'(imem_req);
        end
        check("b_nreq",       32'(nreq),      32'd4);
        check("b_req_full",   32'(imem_req),  32'd0);
        check("b_vld",        32'(out_valid), 32'd1);
        check("b_hold_pc",    out_pc,         32'h0);
        check("b_hold_instr", out_instr,      32'hDEAD_0000);
        tick();
        tgt = acc + 6;
        out_ready = 1'b1;
        #1;
        check("b_req_pop", 32'(imem_req), 32'd0);
        tick();
        out_ready = (acc < tgt);
        #1;
        check("b_resume_req",  32'(imem_req), 32'd1);
        check("b_resume_addr", imem_addr,     32'h10);
        drain(-1);

        // Continue the stream, then redirect while streaming.
        exp_q.push_back(32'h18);
        exp_q.push_back(32'h1C);
        exp_q.push_back(32'h20);
        tgt = acc + 3;
        out_ready = 1'b1;
        drain(-1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        out_ready      = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        tgt = acc + 3;
        #1;
        check("c_vld_r", 32'(out_valid), 32'd0);
        check("c_req_r", 32'(imem_req),  32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("c_req_r1",  32'(imem_req),  32'd1);
        check("c_addr_r1", imem_addr,      32'h100);
        check("c_vld_r1",  32'(out_valid), 32'd0);
        tick();
        check("c_vld_r2",  32'(out_valid), 32'd0);
        check("c_addr_r2", imem_addr,      32'h104);
        tick();
        check("c_vld_r3",  32'(out_valid), 32'd1);
        check("c_pc_r3",   out_pc,         32'h100);
        drain(-1);

        // Back-to-back redirects: only the second target may ever reach decode.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        out_ready      = 1'b1;
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        tgt = acc + 2;
        #1;
        check("d_vld0", 32'(out_valid), 32'd0);
        tick();
        redirect_pc = 32'h300;
        #1;
        check("d_req1", 32'(imem_req),  32'd0);
        check("d_vld1", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("d_req2",  32'(imem_req), 32'd1);
        check("d_addr2", imem_addr,      32'h300);
        drain(-1);

`ifdef IFETCH_PERF_EN
        // Stall-cycle counter: cleared by reset, counts stalls, kept across redirect.
        #1 rst = 1'b0;
        #1;
        check("e_perf_rst", perf, 32'h0);
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        check("e_vld",   32'(out_valid), 32'd1);
        check("e_perf0", perf,           32'd0);
        repeat (5) tick();
        check("e_perf5", perf, 32'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("e_perf_keep", perf, 32'd5);
`endif

        repeat (3) tick();
        check("exp_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Instruction-fetch front end for the 6-stage MIPS pipeline. It sits directly upstream of the decode stage inside `processor`. It generates sequential PCs, issues requests to the synchronous instruction memory, and buffers returned instructions with their PCs in a small prefetch queue. It presents them to decode over a valid/ready handshake and flushes cleanly on branch/jump redirects.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, prefetch queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `imem_req`  out  1  fetch request this cycle
- `imem_addr`  out  ADDR_W  word-aligned fetch address, valid when `imem_req`=1
- `imem_rdata`  in  DATA_W  instruction data, valid exactly one cycle after an accepted `imem_req`
- `redirect_valid`  in  1  branch/jump taken; flush and restart
- `redirect_pc`  in  ADDR_W  restart address; bits [1:0] ignored (treated as 00)
- `out_valid`  out  1  queue head holds a valid instruction
- `out_instr`  out  DATA_W  head instruction
- `out_pc`  out  ADDR_W  PC of head instruction
- `out_ready`  in  1  decode accepts head (low = decode stall)

## Operation
- State:
  - `fetch_pc`
  - `inflight` bit (request issued last cycle)
  - `inflight_pc`
  - queue with `count` (0..DEPTH)
- Issue rule: `imem_req` = 1 when `rst` released, `redirect_valid`=0, and `count + inflight < DEPTH`. `imem_addr` = `fetch_pc`; on issue, `fetch_pc` ← `fetch_pc + 4`, wrapping mod 2^ADDR_W.
- Response: when `inflight`=1 and not squashed, push {`inflight_pc`, `imem_rdata`} into the queue.
- Pop: when `out_valid && out_ready` and no redirect.
- Simultaneous push and pop are legal, including at `count`=DEPTH-1 and `count`=1. `count` is unchanged.
- Redirect (highest priority):
  - queue cleared
  - `count` ← 0
  - any response arriving next cycle discarded (squash flag)
  - `fetch_pc` ← {`redirect_pc`[ADDR_W-1:2], 2'b00}
  - no request issued in the redirect cycle
  - `out_valid` forced 0 in the redirect cycle, and no pop occurs
- Back-to-back redirects: the last one wins; each squashes the prior in-flight response.
- The credit rule guarantees no push into a full queue. An overflow never occurs and needs no handling.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `out_valid`=0, `out_instr`=0, `out_pc`=0
  - `fetch_pc`=`RESET_PC`, `count`=0, `inflight`=0
- Reset is asserted asynchronously and released synchronously to the first rising edge with `rst`=1.
- Latency:
  - request in cycle N → data sampled in N+1, written at end of N+1 → `out_valid` in N+2.
  - First `out_valid` occurs 2 cycles after the first request.
- Redirect in cycle R:
  - request to new PC in R+1
  - `out_valid` with `out_pc`=`redirect_pc` in R+3
- Throughput: 1 instruction/cycle sustained when `out_ready`=1 continuously.
- Decode stall: `out_*` held stable while `out_valid && !out_ready`. Fetch stops once `count + inflight` reaches DEPTH and resumes the cycle after a pop.
- Reset mid-operation: all state returns to reset values immediately. In-flight responses are ignored.

## Configuration
- `IFETCH_PERF_EN` defined:
  - adds output `perf_stall_cycles` (32 bits, reset 0)
  - counts cycles with `out_valid`=1 and `out_ready`=0
  - saturates at 2^32-1
  - not cleared by redirect
- Undefined: port and counter are absent. Functional behaviour is otherwise identical.

## Structure
- Package `ifetch_pkg`:
  - `fetch_entry_t` struct {pc, instr}
  - `INSTR_NOP` constant (32'h0000_0000)
  - `PC_STEP` = 4
- Sub-module `ifetch_fifo`: DEPTH-entry circular buffer of `fetch_entry_t` with push/pop/flush/count and wrap-around pointers. The top level holds the PC, credit, squash and redirect logic.

## Test plan
- Reset release, `out_ready`=1, memory returns addr as data → `imem_addr` 0,4,8,…; first `out_valid` 2 cycles after first req with `out_pc`=0; then one instruction/cycle in order.
- Hold `out_ready`=0 from first `out_valid` → exactly DEPTH=4 requests total, `count`=4, `imem_req`=0. Raise `out_ready` → pops at PC 0,4,8,12; fetch resumes at PC 16 the cycle after the first pop.
- Redirect to 32'h0000_0103 mid-stream → queue flushed, `out_valid`=0 that cycle, in-flight data dropped; req at 0x100 in R+1; `out_pc`=0x100 in R+3.
- Redirects in two consecutive cycles (0x200 then 0x300) → no instruction from 0x200 is ever presented; first output PC is 0x300.
- `RESET_PC`=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- With `IFETCH_PERF_EN`: 5 stall cycles with `out_valid`=1 → `perf_stall_cycles`=5. Async `rst` low mid-stream → all outputs take reset values immediately.
